maze_tx: RTL and testbench
==========================

MAZE_TX -- requirements
Module: maze_tx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1023: cycles to wait for a solver response after the last maze bit.
REQ-002 SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to generate, send and check a maze.
REQ-005 SHALL have port seed  input  16  LFSR seed, sampled with start.
REQ-006 SHALL have port maze  output  1  serial maze bit to the solver (1 = wall).
REQ-007 SHALL have port in_valid  output  1  qualifies maze.
REQ-008 SHALL have ports out_valid, maze_not_valid  input  1 each  solver response strobes.
REQ-009 SHALL have ports out_x, out_y  input  4 each  solver path cell (out_x = column, out_y = row).
REQ-010 SHALL have ports busy, done, path_ok, unsolvable, timeout  output  1 each  status; path_len  output  8  reported cell count.

Function
REQ-011 SHALL implement states IDLE, SEND, WAIT, CHECK, DONE.
REQ-012 IDLE: start=1 -> SEND, latch seed (seed 0 replaced by 16'hACE1), clear status outputs and path_len. Start in any other state is ignored.
REQ-013 SEND: exactly 225 consecutive cycles with in_valid=1, row-major, row 0 column 0 first; on the cycle after the 225th bit, in_valid=0 and the state is WAIT.
REQ-014 Cell rule: border (row or col 0/14) = 1; (1,1) and (13,13) = 0; row and col both odd = 0; all others = lfsr[0] & lfsr[1]. The LFSR advances one step per sent cell.
REQ-015 LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1.
REQ-016 Every sent bit SHALL be stored in a 225-bit map for checking.
REQ-017 WAIT: maze_not_valid=1 -> DONE with unsolvable=1 and path_ok=0 (out_valid is ignored in that cycle); out_valid=1 with maze_not_valid=0 -> CHECK, and that cycle's cell is the first cell checked; TIMEOUT_CYC cycles with no response -> DONE with timeout=1.
REQ-018 CHECK: every cycle with out_valid=1, path_len increments, saturating at 255. The first out_valid=0 cycle -> DONE.
REQ-019 path_ok=1 only if all of the following hold: the first cell is (13,13); the last cell is (1,1); every cell is 0 in the map; each consecutive pair differs by exactly 1 in exactly one coordinate; no cell is outside 0..14.
REQ-020 A maze_not_valid pulse during CHECK SHALL force path_ok=0.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE. Status outputs hold until the next accepted start.
REQ-022 busy=1 in SEND, WAIT and CHECK.
REQ-023 Solver inputs arriving in IDLE or SEND are ignored.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE and set maze, in_valid, busy, done, path_ok, unsolvable, timeout and path_len to 0, and LFSR to 16'hACE1; the map need not be cleared.
REQ-025 Reset mid-SEND SHALL drop in_valid at once; the next start restarts from cell 0.

Configuration
REQ-026 With MAZE_TX_CHECK_EN defined, the map storage and the REQ-019/REQ-020 checks SHALL be present.
REQ-027 Without MAZE_TX_CHECK_EN, the map SHALL be omitted, and path_ok SHALL equal 1 at DONE whenever CHECK ended normally and path_len >= 2; the counting and timeout behaviour are unchanged.

Structure
REQ-028 Package maze_pkg SHALL hold MAZE_DIM=15, MAZE_CELLS=225, the START (1,1) and GOAL (13,13) coordinates, the LFSR default seed 16'hACE1, and the state enum.
REQ-029 The LFSR SHALL be a separate sub-module maze_lfsr with ports clk, rst_n, load, seed, step and value[15:0].

Verification
REQ-030 Start with seed 16'h0001 -> in_valid high for exactly 225 cycles, first 15 bits all 1, bit 16 (cell (1,0)) = 1, bit 17 (cell (1,1)) = 0.
REQ-031 Golden solver returns (13,13),(13,12),...,(1,1) along open cells -> done pulse, path_ok=1, path_len equals the burst length.
REQ-032 Response containing a wall cell or a diagonal step -> path_ok=0 and done=1.
REQ-033 maze_not_valid=1 with out_valid=1 in WAIT -> unsolvable=1, path_ok=0, path_len=0.
REQ-034 No response with TIMEOUT_CYC=16 -> timeout=1 exactly 16 cycles after the last in_valid cycle.
REQ-035 rst_n pulse at bit 100 of SEND -> in_valid=0 immediately; a new start then yields a fresh 225-bit stream; start asserted during SEND is ignored.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared constants, state encoding and indexing helper for the maze transmitter.
package maze_pkg;
  localparam int          MAZE_DIM   = 15;
  localparam int          MAZE_CELLS = 225;
  localparam logic [3:0]  DIM_LAST   = 4'(MAZE_DIM - 1);
  localparam logic [3:0]  START_X    = 4'd1;
  localparam logic [3:0]  START_Y    = 4'd1;
  localparam logic [3:0]  GOAL_X     = 4'd13;
  localparam logic [3:0]  GOAL_Y     = 4'd13;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Row-major cell index: y is the row, x the column.
  function automatic logic [7:0] cell_idx(input logic [3:0] x, input logic [3:0] y);
    return ({4'd0, y} * 8'd15) + {4'd0, x};
  endfunction
endpackage

// File: rtl/maze_lfsr.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1); a zero seed falls back to LFSR_SEED.
module maze_lfsr
  import maze_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] value
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     value <= LFSR_SEED;
    else if (load)  value <= (seed == 16'd0) ? LFSR_SEED : seed;
    else if (step)  value <= {1'b0, value[15:1]} ^ (value[0] ? 16'hB400 : 16'h0000);
  end
endmodule

// File: rtl/maze_tx.sv
// maze_tx: streams a 15x15 LFSR maze to a solver and judges the returned path.
// Define MAZE_TX_CHECK_EN to keep the sent map and fully validate the path.
module maze_tx
  import maze_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] seed,
  output logic        maze,
  output logic        in_valid,
  input  logic        out_valid,
  input  logic        maze_not_valid,
  input  logic [3:0]  out_x,
  input  logic [3:0]  out_y,
  output logic        busy,
  output logic        done,
  output logic        path_ok,
  output logic        unsolvable,
  output logic        timeout,
  output logic [7:0]  path_len
);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  state_e      state;
  logic [3:0]  row, col;
  logic [15:0] lfsr;
  logic [15:0] wait_cnt;
  logic        cell_bit, end_ok, unused_lfsr;

  maze_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state == ST_IDLE && start),
    .seed  (seed),
    .step  (state == ST_SEND),
    .value (lfsr)
  );
  assign unused_lfsr = ^lfsr[15:2];

  always_comb begin
    if (row == 4'd0 || col == 4'd0 || row == DIM_LAST || col == DIM_LAST)
      cell_bit = 1'b1;
    else if ((row == START_Y && col == START_X) || (row == GOAL_Y && col == GOAL_X))
      cell_bit = 1'b0;
    else if (row[0] && col[0])
      cell_bit = 1'b0;
    else
      cell_bit = lfsr[0] & lfsr[1];
  end

  assign in_valid = (state == ST_SEND);
  assign maze     = in_valid & cell_bit;
  assign busy     = (state == ST_SEND) || (state == ST_WAIT) || (state == ST_CHECK);
  assign done     = (state == ST_DONE);

`ifdef MAZE_TX_CHECK_EN
  logic [MAZE_CELLS-1:0] map;
  logic [3:0]            prev_x, prev_y, dx, dy;
  logic                  bad, in_range, cell_open, step_ok;

  always_ff @(posedge clk) begin
    if (state == ST_SEND) map[cell_idx(col, row)] <= cell_bit;
  end

  always_comb begin
    in_range  = (out_x <= DIM_LAST) && (out_y <= DIM_LAST);
    cell_open = in_range && !map[in_range ? cell_idx(out_x, out_y) : 8'd0];
    dx        = (out_x > prev_x) ? out_x - prev_x : prev_x - out_x;
    dy        = (out_y > prev_y) ? out_y - prev_y : prev_y - out_y;
    step_ok   = ({1'b0, dx} + {1'b0, dy}) == 5'd1;
    // A not-valid strobe in the closing cycle must also veto the result.
    end_ok    = !bad && !maze_not_valid && prev_x == START_X && prev_y == START_Y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad    <= 1'b0;
      prev_x <= 4'd0;
      prev_y <= 4'd0;
    end else if (state == ST_WAIT && out_valid && !maze_not_valid) begin
      bad    <= !(out_x == GOAL_X && out_y == GOAL_Y && cell_open);
      prev_x <= out_x;
      prev_y <= out_y;
    end else if (state == ST_CHECK) begin
      if (out_valid) begin
        bad    <= bad | !cell_open | !step_ok;
        prev_x <= out_x;
        prev_y <= out_y;
      end
      if (maze_not_valid) bad <= 1'b1;
    end
  end
`else
  logic unused_resp;
  assign unused_resp = ^{out_x, out_y};
  assign end_ok      = (path_len >= 8'd2);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      row        <= 4'd0;
      col        <= 4'd0;
      wait_cnt   <= 16'd0;
      path_ok    <= 1'b0;
      unsolvable <= 1'b0;
      timeout    <= 1'b0;
      path_len   <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state      <= ST_SEND;
          row        <= 4'd0;
          col        <= 4'd0;
          path_ok    <= 1'b0;
          unsolvable <= 1'b0;
          timeout    <= 1'b0;
          path_len   <= 8'd0;
        end
        ST_SEND: begin
          if (col == DIM_LAST) begin
            col <= 4'd0;
            if (row == DIM_LAST) begin
              state    <= ST_WAIT;
              wait_cnt <= 16'd0;
            end else row <= row + 4'd1;
          end else col <= col + 4'd1;
        end
        ST_WAIT: begin
          if (maze_not_valid) begin
            state      <= ST_DONE;
            unsolvable <= 1'b1;
            path_ok    <= 1'b0;
          end else if (out_valid) begin
            state    <= ST_CHECK;
            path_len <= 8'd1;
          end else if (wait_cnt == TO_LAST) begin
            state   <= ST_DONE;
            timeout <= 1'b1;
          end else wait_cnt <= wait_cnt + 16'd1;
        end
        ST_CHECK: begin
          if (out_valid) begin
            if (path_len != 8'hFF) path_len <= path_len + 8'd1;
          end else begin
            state   <= ST_DONE;
            path_ok <= end_ok;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_maze_tx.sv
// Self-checking bench for maze_tx: randomized seeds and responses against a maze/path model.
module tb_maze_tx;
  localparam int TO = 16;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [15:0] seed = 16'd0;
  logic       out_valid = 1'b0, mnv = 1'b0;
  logic [3:0] out_x = 4'd0, out_y = 4'd0;
  logic       maze, in_valid, busy, done, path_ok, unsolvable, timeout;
  logic [7:0] path_len;

  int checks = 0, errors = 0;
  bit exp_map[225];
  bit got[$];
  int px[$], py[$], gx[$], gy[$];

  always #5 clk = ~clk;

  maze_tx #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .maze(maze), .in_valid(in_valid),
    .out_valid(out_valid), .maze_not_valid(mnv), .out_x(out_x), .out_y(out_y),
    .busy(busy), .done(done), .path_ok(path_ok), .unsolvable(unsolvable),
    .timeout(timeout), .path_len(path_len)
  );

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Expected maze from the cell rules and the tap list of the polynomial.
  task automatic gen_model(input logic [15:0] sd);
    int taps[4] = '{16, 14, 13, 11};
    logic [15:0] mask = 16'd0;
    logic [15:0] st;
    bit lsb;
    foreach (taps[t]) mask[taps[t]-1] = 1'b1;
    st = (sd == 16'd0) ? 16'hACE1 : sd;
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 15; c++) begin
        if (r == 0 || c == 0 || r == 14 || c == 14) exp_map[r*15+c] = 1'b1;
        else if ((r % 2 == 1) && (c % 2 == 1))      exp_map[r*15+c] = 1'b0;
        else                                        exp_map[r*15+c] = st[0] & st[1];
        lsb = st[0];
        st  = st >> 1;
        if (lsb) st = st ^ mask;
      end
  endtask

  // Shortest open path (13,13) -> (1,1) into px/py.
  task automatic bfs(output bit found);
    int par[225];
    bit seen[225];
    int q[$];
    int dr[4] = '{-1, 1, 0, 0};
    int dc[4] = '{0, 0, -1, 1};
    int cur, nr, nc, nb;
    px.delete(); py.delete();
    foreach (seen[i]) seen[i] = 1'b0;
    q.push_back(16); seen[16] = 1'b1; par[16] = -1;
    while (q.size() > 0) begin
      cur = q.pop_front();
      for (int d = 0; d < 4; d++) begin
        nr = cur / 15 + dr[d];
        nc = cur % 15 + dc[d];
        if (nr < 0 || nr > 14 || nc < 0 || nc > 14) continue;
        nb = nr * 15 + nc;
        if (seen[nb] || exp_map[nb]) continue;
        seen[nb] = 1'b1; par[nb] = cur; q.push_back(nb);
      end
    end
    found = seen[13*15+13];
    if (found) begin
      cur = 13*15+13;
      while (cur != -1) begin
        px.push_back(cur % 15); py.push_back(cur / 15);
        cur = par[cur];
      end
    end
  endtask

  function automatic bit ref_path_ok();
`ifdef MAZE_TX_CHECK_EN
    if (px.size() == 0) return 1'b0;
    if (px[0] != 13 || py[0] != 13) return 1'b0;
    if (px[px.size()-1] != 1 || py[py.size()-1] != 1) return 1'b0;
    foreach (px[i]) begin
      if (px[i] > 14 || py[i] > 14) return 1'b0;
      if (exp_map[py[i]*15 + px[i]]) return 1'b0;
      if (i > 0 && iabs(px[i]-px[i-1]) + iabs(py[i]-py[i-1]) != 1) return 1'b0;
    end
    return 1'b1;
`else
    return px.size() >= 2;
`endif
  endfunction

  task automatic pick_seed(output logic [15:0] sd);
    bit found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      sd = 16'($urandom);
      gen_model(sd);
      bfs(found);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL pick_seed: no solvable maze found, required one"); end
    gx = px; gy = py;
  endtask

  // Starts a transaction and captures the stream; returns at the first cycle after it.
  task automatic send_capture(input logic [15:0] sd, input bit noise);
    int bad = -1;
    gen_model(sd);
    @(negedge clk); seed = sd; start = 1'b1;
    @(negedge clk); start = 1'b0; seed = 16'($urandom);
    checks++;
    if ({path_ok, unsolvable, timeout, done, path_len} !== 12'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_clear: ok=%b uns=%b to=%b done=%b len=%0d busy=%b, required zeros and busy", path_ok, unsolvable, timeout, done, path_len, busy);
    end
    got.delete();
    for (int k = 0; k < 300 && in_valid === 1'b1; k++) begin
      got.push_back(maze);
      if (noise) begin out_valid = 1'($urandom); mnv = 1'($urandom); out_x = 4'($urandom); out_y = 4'($urandom); end
      @(negedge clk);
    end
    out_valid = 1'b0; mnv = 1'b0;
    checks++;
    if (got.size() != 225) begin errors++; $display("FAIL stream_len: got %0d bits, required 225", got.size()); end
    else begin
      foreach (got[i]) if (bad < 0 && got[i] !== exp_map[i]) bad = i;
      checks++;
      if (bad >= 0) begin errors++; $display("FAIL stream_bits seed=%h: bit %0d is %b, required %b", sd, bad, got[bad], exp_map[bad]); end
    end
  endtask

  task automatic drive_resp();
    foreach (px[i]) begin
      out_valid = 1'b1; out_x = 4'(px[i]); out_y = 4'(py[i]);
      @(negedge clk);
    end
    out_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    for (k = 0; k < 40 && done !== 1'b1; k++) @(negedge clk);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL %s_done: no done within 40 cycles, required a pulse", tag); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; seed = 16'h1234;
    repeat (3) @(negedge clk);
    checks++;
    if ({maze, in_valid, busy, done, path_ok, unsolvable, timeout, path_len} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required all zero", {maze, in_valid, busy, done, path_ok, unsolvable, timeout, path_len});
    end
    start = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_valid !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b in_valid=%b, required 0 0", busy, in_valid); end
  endtask

  task automatic test_seed_one();
    int n = 0;
    send_capture(16'h0001, 1'b1);
    if (got.size() >= 17) begin
      checks++;
      if (got[0:14] != '{15{1'b1}} || got[15] !== 1'b1 || got[16] !== 1'b0) begin
        errors++; $display("FAIL seed1_prefix: bits0..16 wrong, bit15=%b bit16=%b, required first 16 ones then 0", got[15], got[16]);
      end
    end
    for (int k = 0; k < 100 && timeout !== 1'b1; k++) begin n++; @(negedge clk); end
    checks++;
    if (n != TO) begin errors++; $display("FAIL timeout_latency: %0d idle cycles before timeout, required %0d", n, TO); end
    wait_done("timeout");
    checks++;
    if (timeout !== 1'b1 || path_ok !== 1'b0 || unsolvable !== 1'b0 || path_len !== 8'd0) begin
      errors++; $display("FAIL timeout_status: to=%b ok=%b uns=%b len=%0d, required 1 0 0 0", timeout, path_ok, unsolvable, path_len);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || timeout !== 1'b1) begin
      errors++; $display("FAIL done_width: done=%b busy=%b to=%b, required 0 0 1", done, busy, timeout);
    end
  endtask

  task automatic test_streams();
    logic [15:0] sds[3];
    sds[0] = 16'h0000; sds[1] = 16'($urandom); sds[2] = 16'($urandom);
    foreach (sds[i]) begin
      send_capture(sds[i], 1'b1);
      wait_done("stream");
      checks++;
      if (timeout !== 1'b1 || unsolvable !== 1'b0) begin errors++; $display("FAIL stream_timeout: to=%b uns=%b, required 1 0", timeout, unsolvable); end
    end
  endtask

  task automatic run_path(input logic [15:0] sd, input string tag);
    int exp_len;
    bit exp_ok;
    send_capture(sd, 1'b0);
    exp_ok  = ref_path_ok();
    exp_len = (px.size() > 255) ? 255 : px.size();
    drive_resp();
    wait_done(tag);
    checks++;
    if (path_ok !== exp_ok || path_len !== 8'(exp_len) || unsolvable !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL %s_result: ok=%b len=%0d uns=%b to=%b, required ok=%b len=%0d uns=0 to=0", tag, path_ok, path_len, unsolvable, timeout, exp_ok, exp_len);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || path_ok !== exp_ok) begin errors++; $display("FAIL %s_hold: done=%b ok=%b, required 0 %b", tag, done, path_ok, exp_ok); end
  endtask

  task automatic test_golden();
    logic [15:0] sd;
    for (int t = 0; t < 3; t++) begin
      pick_seed(sd);
      px = gx; py = gy;
      run_path(sd, "golden");
      checks++;
      if (path_ok !== 1'b1) begin errors++; $display("FAIL golden_ok: path_ok=%b, required 1", path_ok); end
    end
  endtask

  task automatic test_bad_paths();
    logic [15:0] sd;
    int n;
    pick_seed(sd);
    // Detour through the border wall next to the goal.
    px = gx; py = gy;
    px.push_front(13); py.push_front(14);
    px.push_front(13); py.push_front(13);
    run_path(sd, "wall");
    // Cut one corner of the shortest path into a diagonal step.
    px = gx; py = gy;
    for (int i = 0; i + 2 < px.size(); i++)
      if (iabs(px[i]-px[i+2]) == 1 && iabs(py[i]-py[i+2]) == 1) begin
        px.delete(i+1); py.delete(i+1); break;
      end
    run_path(sd, "diag");
    for (int t = 0; t < 3; t++) begin
      px.delete(); py.delete();
      n = (t == 2) ? 260 : int'($urandom_range(2, 6));
      for (int i = 0; i < n; i++) begin px.push_back($urandom_range(0, 15)); py.push_back($urandom_range(0, 15)); end
      run_path(16'($urandom), "random");
    end
  endtask

  task automatic test_unsolvable();
    send_capture(16'($urandom), 1'b0);
    out_valid = 1'b1; mnv = 1'b1; out_x = 4'd13; out_y = 4'd13;
    @(negedge clk);
    out_valid = 1'b0; mnv = 1'b0;
    wait_done("unsolvable");
    checks++;
    if (unsolvable !== 1'b1 || path_ok !== 1'b0 || path_len !== 8'd0 || timeout !== 1'b0) begin
      errors++; $display("FAIL unsolvable_status: uns=%b ok=%b len=%0d to=%b, required 1 0 0 0", unsolvable, path_ok, path_len, timeout);
    end
  endtask

  task automatic test_mnv_in_check();
    logic [15:0] sd;
    bit exp_ok;
    pick_seed(sd);
    send_capture(sd, 1'b0);
`ifdef MAZE_TX_CHECK_EN
    exp_ok = 1'b0;
`else
    exp_ok = 1'b1;
`endif
    foreach (gx[i]) begin
      out_valid = 1'b1; out_x = 4'(gx[i]); out_y = 4'(gy[i]); mnv = (i == gx.size() / 2);
      @(negedge clk);
    end
    out_valid = 1'b0; mnv = 1'b0;
    wait_done("mnv_check");
    checks++;
    if (path_ok !== exp_ok || path_len !== 8'(gx.size())) begin
      errors++; $display("FAIL mnv_check: ok=%b len=%0d, required %b %0d", path_ok, path_len, exp_ok, gx.size());
    end
  endtask

  task automatic test_reset_mid_send();
    logic [15:0] sd = 16'($urandom);
    int bad = -1;
    gen_model(sd);
    @(negedge clk); seed = sd; start = 1'b1;
    @(negedge clk); start = 1'b0;
    got.delete();
    for (int k = 0; k < 100 && in_valid === 1'b1; k++) begin
      got.push_back(maze);
      start = (k == 50);
      seed  = 16'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    foreach (got[i]) if (bad < 0 && got[i] !== exp_map[i]) bad = i;
    checks++;
    if (got.size() != 100 || bad >= 0 || in_valid !== 1'b1) begin
      errors++; $display("FAIL start_in_send: %0d bits, first bad %0d, in_valid=%b, required 100 matching bits and in_valid 1", got.size(), bad, in_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_valid !== 1'b0 || busy !== 1'b0 || maze !== 1'b0) begin
      errors++; $display("FAIL reset_mid_send: in_valid=%b busy=%b maze=%b, required 0 0 0", in_valid, busy, maze);
    end
    @(negedge clk); rst_n = 1'b1;
    send_capture(sd, 1'b0);
    wait_done("after_reset");
  endtask

  initial begin
    test_reset();
    test_seed_one();
    test_streams();
    test_golden();
    test_bad_paths();
    test_unsolvable();
    test_mnv_in_check();
    test_reset_mid_send();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
